// File: rtl/alu_cmd_ctrl_if.sv
// Signal bundle between alu_cmd_ctrl (master) and its UART RX/TX paths and the ALU (slave).
interface alu_cmd_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   ALU_A;
  logic [DATA_WIDTH-1:0]   ALU_B;
  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic                    CLK_GATE_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VALID;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TX_BUSY;
  logic                    FRAME_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VALID, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Parses UART command frames, drives the ALU and returns its 16-bit result LSB-first.
// Optional inter-byte timeout is enabled with `define CMD_TIMEOUT_EN.
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
`ifdef CMD_TIMEOUT_EN
  , parameter int                  TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  alu_cmd_ctrl_if.master      bus
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT,
    TX_LSB, TX_LSB_ACK, TX_MSB, TX_MSB_ACK
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_alu_a;
  logic [DATA_WIDTH-1:0]   r_alu_b;
  logic [3:0]              r_alu_fun;
  logic                    r_alu_en;
  logic                    r_frame_err;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0]   r_tx_last;

  logic                    w_tx_vld;
  logic [DATA_WIDTH-1:0]   w_tx_byte;

`ifdef CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]        r_tmo_cnt;
`endif

  // Strobe is decoded from state and TX_BUSY so the first byte leaves 3 cycles after the last RX byte.
  assign w_tx_vld  = ((r_state == TX_LSB) || (r_state == TX_MSB)) && !bus.TX_BUSY;
  assign w_tx_byte = (r_state == TX_MSB) ? r_result[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : r_result[DATA_WIDTH-1:0];

  assign bus.ALU_A       = r_alu_a;
  assign bus.ALU_B       = r_alu_b;
  assign bus.ALU_FUN     = r_alu_fun;
  assign bus.ALU_EN      = r_alu_en;
  assign bus.CLK_GATE_EN = (r_state == ALU_REQ) || (r_state == ALU_WAIT);
  assign bus.TX_D_VLD    = w_tx_vld;
  assign bus.TX_P_DATA   = w_tx_vld ? w_tx_byte : r_tx_last;
  assign bus.FRAME_ERR   = r_frame_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= '0;
      r_alu_en    <= 1'b0;
      r_frame_err <= 1'b0;
      r_result    <= '0;
      r_tx_last   <= '0;
`ifdef CMD_TIMEOUT_EN
      r_tmo_cnt   <= '0;
`endif
    end else begin
      r_alu_en    <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_ALU_OP)       r_state <= GET_A;
          else if (bus.RX_P_DATA == CMD_ALU_NOP) r_state <= GET_FUN;
          else                                   r_frame_err <= 1'b1;
        end
        GET_A: if (bus.RX_D_VLD) begin
          r_alu_a <= bus.RX_P_DATA;
          r_state <= GET_B;
        end
        GET_B: if (bus.RX_D_VLD) begin
          r_alu_b <= bus.RX_P_DATA;
          r_state <= GET_FUN;
        end
        GET_FUN: if (bus.RX_D_VLD) begin
          r_alu_fun <= bus.RX_P_DATA[3:0];
          r_alu_en  <= 1'b1;
          r_state   <= ALU_REQ;
        end
        ALU_REQ: r_state <= ALU_WAIT;
        ALU_WAIT: if (bus.ALU_OUT_VALID) begin
          r_result <= bus.ALU_OUT;
          r_state  <= TX_LSB;
        end
        TX_LSB: if (w_tx_vld) begin
          r_tx_last <= w_tx_byte;
          r_state   <= TX_LSB_ACK;
        end
        TX_LSB_ACK: if (bus.TX_BUSY) r_state <= TX_MSB;
        TX_MSB: if (w_tx_vld) begin
          r_tx_last <= w_tx_byte;
          r_state   <= TX_MSB_ACK;
        end
        TX_MSB_ACK: if (bus.TX_BUSY) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
`ifdef CMD_TIMEOUT_EN
      // Abandon a stalled frame; operand registers keep whatever was already loaded.
      if ((r_state inside {GET_A, GET_B, GET_FUN}) && !bus.RX_D_VLD) begin
        if (r_tmo_cnt == TMO_MAX) begin
          r_state     <= IDLE;
          r_frame_err <= 1'b1;
          r_tmo_cnt   <= '0;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end else begin
        r_tmo_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered ALU model and a simple UART TX busy model.
module tb_alu_cmd_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if #(.DATA_WIDTH(8)) bus();

  alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // ALU: registered result one cycle after ALU_EN; 0 add, 1 sub, 2 mul.
  always @(posedge CLK) begin
    bus.ALU_OUT_VALID <= bus.ALU_EN;
    case (bus.ALU_FUN)
      4'd0:    bus.ALU_OUT <= {8'h00, bus.ALU_A} + {8'h00, bus.ALU_B};
      4'd1:    bus.ALU_OUT <= {8'h00, bus.ALU_A} - {8'h00, bus.ALU_B};
      4'd2:    bus.ALU_OUT <= {8'h00, bus.ALU_A} * {8'h00, bus.ALU_B};
      default: bus.ALU_OUT <= 16'h0000;
    endcase
  end

  // UART TX: busy for 4 cycles after each strobe, plus a forced-busy override.
  int   busy_cnt   = 0;
  logic busy_force = 1'b0;
  assign bus.TX_BUSY = busy_force || (busy_cnt != 0);
  always @(posedge CLK) begin
    if (bus.TX_D_VLD) busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] tx_q[$];
  int alu_en_cnt = 0;
  int gate_cnt   = 0;
  int ferr_cnt   = 0;
  always @(negedge CLK) begin
    if (bus.TX_D_VLD === 1'b1) tx_q.push_back(bus.TX_P_DATA);
    if (bus.ALU_EN === 1'b1) alu_en_cnt++;
    if (bus.CLK_GATE_EN === 1'b1) gate_cnt++;
    if (bus.FRAME_ERR === 1'b1) ferr_cnt++;
  end

  task automatic clear_mon();
    @(posedge CLK);
    tx_q.delete();
    alu_en_cnt = 0;
    gate_cnt   = 0;
    ferr_cnt   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int cyc = 0;
    while (tx_q.size() < n && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    repeat (8) @(negedge CLK);
  endtask

  function automatic logic [15:0] tx_pair();
    return (tx_q.size() >= 2) ? {tx_q[1], tx_q[0]} : 16'hxxxx;
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    bus.RX_D_VLD = 1'b0;
    bus.RX_P_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== 20'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h expected 00000", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN});
    end
    n_checks++;
    if ({bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_D_VLD, bus.FRAME_ERR, bus.TX_P_DATA} !== 12'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 000",
                         {bus.ALU_EN, bus.CLK_GATE_EN, bus.TX_D_VLD, bus.FRAME_ERR, bus.TX_P_DATA});
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_add();
    clear_mon();
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    n_checks++;
    if (bus.ALU_EN !== 1'b1) begin
      n_fail++; $display("FAIL add_en_latency: ALU_EN got %b expected 1", bus.ALU_EN);
    end
    n_checks++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== {8'h05, 8'h03, 4'h0}) begin
      n_fail++; $display("FAIL add_operands: got %h expected 05030", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN});
    end
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({bus.TX_D_VLD, bus.TX_P_DATA} !== {1'b1, 8'h08}) begin
      n_fail++; $display("FAIL add_tx_latency: vld/data got %b/%h expected 1/08", bus.TX_D_VLD, bus.TX_P_DATA);
    end
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0008) begin
      n_fail++; $display("FAIL add_tx: got %h expected 0008 (size %0d)", tx_pair(), tx_q.size());
    end
    n_checks++;
    if (alu_en_cnt !== 1 || gate_cnt !== 2) begin
      n_fail++; $display("FAIL add_pulses: en %0d gate %0d expected 1 2", alu_en_cnt, gate_cnt);
    end
    n_checks++;
    if (bus.TX_P_DATA !== 8'h00) begin
      n_fail++; $display("FAIL add_tx_hold: got %h expected 00", bus.TX_P_DATA);
    end
  endtask

  task automatic test_mul_nop();
    clear_mon();
    send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h02);
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0200) begin
      n_fail++; $display("FAIL mul_tx: got %h expected 0200", tx_pair());
    end
    clear_mon();
    send_byte(8'hDD); send_byte(8'h01);
    n_checks++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN} !== {8'h10, 8'h20, 4'h1}) begin
      n_fail++; $display("FAIL nop_operands: got %h expected 10201", {bus.ALU_A, bus.ALU_B, bus.ALU_FUN});
    end
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'hFFF0) begin
      n_fail++; $display("FAIL nop_tx: got %h expected fff0", tx_pair());
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_byte(8'h55);
    n_checks++;
    if (bus.FRAME_ERR !== 1'b1) begin
      n_fail++; $display("FAIL ferr_pulse: got %b expected 1", bus.FRAME_ERR);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (ferr_cnt !== 1 || alu_en_cnt !== 0) begin
      n_fail++; $display("FAIL ferr_count: ferr %0d en %0d expected 1 0", ferr_cnt, alu_en_cnt);
    end
    clear_mon();
    send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0002) begin
      n_fail++; $display("FAIL ferr_recover_tx: got %h expected 0002", tx_pair());
    end
  endtask

  task automatic test_tx_busy();
    clear_mon();
    busy_force = 1'b1;
    send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      bus.RX_D_VLD  = (i % 6 == 3);
      bus.RX_P_DATA = (i < 25) ? 8'hCC : 8'h00;
    end
    bus.RX_D_VLD = 1'b0;
    n_checks++;
    if (tx_q.size() !== 0) begin
      n_fail++; $display("FAIL busy_hold: got %0d strobes expected 0", tx_q.size());
    end
    busy_force = 1'b0;
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0007) begin
      n_fail++; $display("FAIL busy_tx: got %h expected 0007", tx_pair());
    end
    repeat (20) @(negedge CLK);
    n_checks++;
    if (alu_en_cnt !== 1 || tx_q.size() !== 2) begin
      n_fail++; $display("FAIL busy_dropped_rx: en %0d bytes %0d expected 1 2", alu_en_cnt, tx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_byte(8'hCC); send_byte(8'h07);
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if ({bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN, bus.CLK_GATE_EN,
         bus.TX_D_VLD, bus.FRAME_ERR, bus.TX_P_DATA} !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got %h expected 00000000",
                         {bus.ALU_A, bus.ALU_B, bus.ALU_FUN, bus.ALU_EN, bus.CLK_GATE_EN,
                          bus.TX_D_VLD, bus.FRAME_ERR, bus.TX_P_DATA});
    end
    @(negedge CLK);
    RST = 1'b1;
    clear_mon();
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h01);
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0000 || alu_en_cnt !== 1) begin
      n_fail++; $display("FAIL reset_mid_frame: tx %h en %0d expected 0000 1", tx_pair(), alu_en_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'hCC); send_byte(8'h01);
    repeat (1100) @(negedge CLK);
`ifdef CMD_TIMEOUT_EN
    n_checks++;
    if (ferr_cnt !== 1 || bus.ALU_A !== 8'h01) begin
      n_fail++; $display("FAIL timeout_abort: ferr %0d A %h expected 1 01", ferr_cnt, bus.ALU_A);
    end
    send_byte(8'h02); send_byte(8'h00);
    repeat (20) @(negedge CLK);
    n_checks++;
    if (alu_en_cnt !== 0 || tx_q.size() !== 0) begin
      n_fail++; $display("FAIL timeout_idle: en %0d bytes %0d expected 0 0", alu_en_cnt, tx_q.size());
    end
`else
    n_checks++;
    if (ferr_cnt !== 0 || alu_en_cnt !== 0) begin
      n_fail++; $display("FAIL timeout_wait: ferr %0d en %0d expected 0 0", ferr_cnt, alu_en_cnt);
    end
    send_byte(8'h02); send_byte(8'h00);
    wait_tx(2);
    n_checks++;
    if (tx_pair() !== 16'h0003 || bus.ALU_B !== 8'h02) begin
      n_fail++; $display("FAIL timeout_late_tx: tx %h B %h expected 0003 02", tx_pair(), bus.ALU_B);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_nop();
    test_frame_err();
    test_tx_busy();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer that drives the ALU and consumes its result. It parses byte frames from the UART receive path, loads the operands and function code, and pulses the ALU enable. It captures the registered 16-bit result and returns it LSB-first to the UART transmit path. It also provides the ALU clock-gate enable for the low-power domain.

Parameters:
DATA_WIDTH, 8, operand/byte width; ALU result is 2*DATA_WIDTH.
CMD_ALU_OP, 8'hCC, frame opcode: CMD, A, B, FUN.
CMD_ALU_NOP, 8'hDD, frame opcode: CMD, FUN (reuses stored A/B).
TIMEOUT_CYCLES, 1024, inter-byte timeout; used only with CMD_TIMEOUT_EN.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte (already synchronized)
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_A  out  DATA_WIDTH  operand A register
ALU_B  out  DATA_WIDTH  operand B register
ALU_FUN  out  4  function code register
ALU_EN  out  1  one-cycle ALU enable pulse
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  2*DATA_WIDTH  registered ALU result
ALU_OUT_VALID  in  1  result valid
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  one-cycle transmit strobe
TX_BUSY  in  1  transmitter busy (already synchronized)
FRAME_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset (RST low, asynchronous): state IDLE. All outputs are 0, including ALU_A, ALU_B, ALU_FUN and the result register. Reset mid-frame aborts the frame silently.
- Bytes are accepted only when RX_D_VLD=1 in IDLE, GET_A, GET_B or GET_FUN. Bytes arriving in any other state are dropped.
- IDLE:
  - byte==CMD_ALU_OP -> GET_A.
  - byte==CMD_ALU_NOP -> GET_FUN.
  - Any other byte -> FRAME_ERR pulse for 1 cycle; stay in IDLE.
- GET_A: byte -> ALU_A; go to GET_B.
- GET_B: byte -> ALU_B; go to GET_FUN.
- GET_FUN: byte[3:0] -> ALU_FUN (upper bits ignored); go to ALU_REQ.
- ALU_REQ: ALU_EN=1 for exactly 1 cycle; go to ALU_WAIT.
- ALU_WAIT:
  - On ALU_OUT_VALID=1, capture ALU_OUT into the result register and go to TX_LSB.
  - Nominal latency: ALU_OUT_VALID arrives 1 cycle after ALU_EN.
- CLK_GATE_EN=1 in ALU_REQ and ALU_WAIT only; decoded combinationally from state.
- TX_LSB:
  - When TX_BUSY=0: TX_P_DATA=result[7:0], TX_D_VLD=1 for 1 cycle; go to TX_LSB_ACK.
  - While TX_BUSY=1, wait with TX_D_VLD=0.
- TX_LSB_ACK: wait for TX_BUSY=1, then go to TX_MSB.
- TX_MSB: same handshake as TX_LSB with result[15:8]; go to TX_MSB_ACK.
- TX_MSB_ACK: wait for TX_BUSY=1, then go to IDLE.
- TX_P_DATA holds its last value between strobes.
- ALU_A/B/FUN hold their values across frames, so a CMD_ALU_NOP frame reuses the last A and B.
- Minimum frame-to-response latency: last RX byte -> ALU_EN is 1 cycle; -> first TX_D_VLD is 3 cycles with TX_BUSY=0.
- Simultaneous events: RX_D_VLD arriving in the same cycle as a state exit is evaluated against the current state only.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined:
  - A counter runs in GET_A, GET_B and GET_FUN, cleared on every accepted byte and on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte received, the block goes to IDLE, pulses FRAME_ERR for 1 cycle, and leaves ALU_A/B/FUN unchanged.
- Undefined: no counter; the block waits indefinitely for the next byte.

Test Plan:
- CC,05,03,00 with ALU model returning A+B -> ALU_A=05, ALU_B=03, ALU_FUN=0; one ALU_EN pulse; CLK_GATE_EN high 2 cycles; TX bytes 08 then 00.
- CC,10,20,02 -> result 0200 -> TX 00 then 02. Follow with DD,01 -> A=10, B=20 reused, result FFF0 -> TX F0 then FF.
- Byte 55 in IDLE -> FRAME_ERR 1-cycle pulse, no ALU_EN. A following CC,01,01,00 frame completes normally with TX 02,00.
- TX_BUSY held high 50 cycles during TX_LSB -> TX_D_VLD stays 0 until TX_BUSY falls. RX bytes injected during TX are ignored; no extra ALU_EN.
- RST pulsed low after CC,07 -> all outputs 0 immediately. A new frame CC,02,02,01 -> TX 00,00.
- Timeout: CC,01 then silence for TIMEOUT_CYCLES. With CMD_TIMEOUT_EN -> FRAME_ERR pulse, IDLE, ALU_A unchanged. Without CMD_TIMEOUT_EN -> block remains in GET_B; a late 02,00 completes with TX 03,00.
